// File: rtl/alu_arbiter_if.sv
// Handshake, response and shared-ALU bus between two requesters and alu_arbiter.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 64
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;

  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready,
    input  alu_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_err,
    output alu_a, alu_b, alu_ctrl,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready,
    output alu_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_err,
    input  alu_a, alu_b, alu_ctrl,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
module alu_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic             gnt_idle;
  logic             op_ok;
  logic             rsp_done;
  logic             req0_ready, req1_ready;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp_err;
  logic [3:0]       alu_ctrl;

  always_comb begin
    unique case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100: op_ok = 1'b1;
      default:                                     op_ok = 1'b0;
    endcase
  end

  // On a tie, ptr_q holds the last granted id, so the other one wins.
  always_comb begin
    gnt_idle = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_idle = ~ptr_q;
    end else if (bus.req1_valid) begin
      gnt_idle = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_err    = 1'b0;
    rsp_done   = 1'b0;
    alu_ctrl   = 4'b0000;

    case (state_q)
      StIdle: begin
        // Gated by rst_n so ready is low while reset is asserted.
        req0_ready = rst_n && !gnt_idle && bus.req0_valid;
        req1_ready = rst_n && gnt_idle && bus.req1_valid;
        if (req0_ready || req1_ready) begin
          gnt_d   = gnt_idle;
          a_d     = gnt_idle ? bus.req1_a  : bus.req0_a;
          b_d     = gnt_idle ? bus.req1_b  : bus.req0_b;
          op_d    = gnt_idle ? bus.req1_op : bus.req0_op;
          state_d = StExec;
        end
      end
      StExec: begin
        alu_ctrl = op_ok ? op_q : 4'b0000;
        result_d = op_ok ? bus.alu_result : '0;
        err_d    = !op_ok;
        state_d  = StResp;
      end
      StResp: begin
        rsp0_valid = !gnt_q;
        rsp1_valid = gnt_q;
        rsp_err    = err_q;
        rsp_done   = gnt_q ? bus.rsp1_ready : bus.rsp0_ready;
        if (rsp_done) begin
          ptr_d   = gnt_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= 1'b1;
      gnt_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 4'b0000;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.req0_ready = req0_ready;
  assign bus.req1_ready = req1_ready;
  assign bus.rsp0_valid = rsp0_valid;
  assign bus.rsp1_valid = rsp1_valid;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = rsp_err;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, tie-break, round-robin, latency,
// backpressure, illegal op and reset while an operation is in flight.
module tb_alu_arbiter;
  localparam int unsigned WIDTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU on the shared bus.
  always_comb begin
    case (bus.alu_ctrl)
      4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
      4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
      4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
      4'b0100: bus.alu_result = bus.alu_a ^ bus.alu_b;
      default: bus.alu_result = '0;
    endcase
  end

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 4'b0000;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 4'b0000;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    rst_n = 1'b0;
    #3;
    checks++; if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin failures++;
      $display("FAIL reset_ready got=%b exp=00", {bus.req1_ready, bus.req0_ready}); end
    checks++; if ({bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err} !== 3'b000) begin failures++;
      $display("FAIL reset_rsp got=%b exp=000", {bus.rsp1_valid, bus.rsp0_valid, bus.rsp_err}); end
    checks++; if (bus.alu_ctrl !== 4'b0000) begin failures++;
      $display("FAIL reset_alu_ctrl got=%h exp=0", bus.alu_ctrl); end
    checks++; if (bus.rsp_result !== 64'h0 || bus.alu_a !== 64'h0) begin failures++;
      $display("FAIL reset_regs result=%h alu_a=%h exp=0", bus.rsp_result, bus.alu_a); end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_tie();
    bus.req0_a = 64'd3;    bus.req0_b = 64'd5;    bus.req0_op = 4'b0110;
    bus.req1_a = 64'hF0;   bus.req1_b = 64'hFF;   bus.req1_op = 4'b0100;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin failures++;
      $display("FAIL tie_first_grant got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.req1_ready !== 1'b0) begin failures++;
      $display("FAIL tie_exec busy=%0b req1_ready=%0b exp=1,0", bus.busy, bus.req1_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++; if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'b01) begin failures++;
      $display("FAIL tie_rsp0_valid got=%b exp=01", {bus.rsp1_valid, bus.rsp0_valid}); end
    checks++; if (bus.rsp_result !== 64'hFFFF_FFFF_FFFF_FFFE || bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL tie_sub_result got=%h err=%0b exp=fffffffffffffffe,0",
               bus.rsp_result, bus.rsp_err); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL tie_second_grant got=%b busy=%0b exp=10,0",
               {bus.req1_ready, bus.req0_ready}, bus.busy); end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'b10) begin failures++;
      $display("FAIL tie_rsp1_valid got=%b exp=10", {bus.rsp1_valid, bus.rsp0_valid}); end
    checks++; if (bus.rsp_result !== 64'h0F || bus.rsp_err !== 1'b0) begin failures++;
      $display("FAIL tie_xor_result got=%h err=%0b exp=f,0", bus.rsp_result, bus.rsp_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic exp;
    bus.req0_a = 64'h10; bus.req0_b = 64'h01; bus.req0_op = 4'b0010;
    bus.req1_a = 64'h10; bus.req1_b = 64'h01; bus.req1_op = 4'b0110;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 1);
      @(negedge clk);
      checks++; if ({bus.req1_ready, bus.req0_ready} !== (exp ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_grant op=%0d got=%b exp=%b", i, {bus.req1_ready, bus.req0_ready},
                 exp ? 2'b10 : 2'b01); end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checks++; if ({bus.rsp1_valid, bus.rsp0_valid} !== (exp ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rr_rsp_valid op=%0d got=%b exp=%b", i, {bus.rsp1_valid, bus.rsp0_valid},
                 exp ? 2'b10 : 2'b01); end
      checks++; if (bus.rsp_result !== (exp ? 64'h0F : 64'h11)) begin failures++;
        $display("FAIL rr_result op=%0d got=%h exp=%h", i, bus.rsp_result,
                 exp ? 64'h0F : 64'h11); end
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  task automatic test_single();
    bus.req0_a = 64'd5; bus.req0_b = 64'd3; bus.req0_op = 4'b0010;
    bus.rsp0_ready = 1'b1;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.req0_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++;
      $display("FAIL single_c0 ready=%0b busy=%0b exp=1,0", bus.req0_ready, bus.busy); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.rsp0_valid !== 1'b0) begin failures++;
      $display("FAIL single_c1 busy=%0b rsp0_valid=%0b exp=1,0", bus.busy, bus.rsp0_valid); end
    checks++; if (bus.alu_a !== 64'd5 || bus.alu_b !== 64'd3 || bus.alu_ctrl !== 4'b0010) begin
      failures++;
      $display("FAIL single_alu_drive a=%h b=%h ctrl=%h exp=5,3,2",
               bus.alu_a, bus.alu_b, bus.alu_ctrl); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rsp0_valid !== 1'b1 || bus.busy !== 1'b1) begin failures++;
      $display("FAIL single_c2 rsp0_valid=%0b busy=%0b exp=1,1", bus.rsp0_valid, bus.busy); end
    checks++; if (bus.rsp_result !== 64'd8 || bus.rsp_err !== 1'b0) begin failures++;
      $display("FAIL single_result got=%h err=%0b exp=8,0", bus.rsp_result, bus.rsp_err); end
    checks++; if (bus.alu_ctrl !== 4'b0000) begin failures++;
      $display("FAIL single_ctrl_resp got=%h exp=0", bus.alu_ctrl); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.rsp0_valid !== 1'b0) begin failures++;
      $display("FAIL single_c3 busy=%0b rsp0_valid=%0b exp=0,0", bus.busy, bus.rsp0_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bus.req0_a = 64'd1;  bus.req0_b = 64'd2;  bus.req0_op = 4'b0001;
    bus.req1_a = 64'hAA; bus.req1_b = 64'h0F; bus.req1_op = 4'b0100;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin failures++;
      $display("FAIL bp_grant got=%b exp=10", {bus.req1_ready, bus.req0_ready}); end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'b10 || bus.req0_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_valid cyc=%0d rsp=%b req0_ready=%0b exp=10,0", i,
                 {bus.rsp1_valid, bus.rsp0_valid}, bus.req0_ready); end
      checks++; if (bus.rsp_result !== 64'hA5 || bus.rsp_err !== 1'b0) begin failures++;
        $display("FAIL bp_hold_data cyc=%0d got=%h err=%0b exp=a5,0", i, bus.rsp_result,
                 bus.rsp_err); end
      @(posedge clk); #1;
    end
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.rsp1_valid !== 1'b1) begin failures++;
      $display("FAIL bp_release_valid got=%0b exp=1", bus.rsp1_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.req0_ready !== 1'b1) begin failures++;
      $display("FAIL bp_back_idle busy=%0b req0_ready=%0b exp=0,1", bus.busy, bus.req0_ready); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_result !== 64'd3) begin failures++;
      $display("FAIL bp_req0_result valid=%0b got=%h exp=1,3", bus.rsp0_valid, bus.rsp_result); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    bus.req1_a = 64'h55; bus.req1_b = 64'h33; bus.req1_op = 4'b1111;
    bus.rsp1_ready = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.req1_ready !== 1'b1) begin failures++;
      $display("FAIL ill_grant got=%0b exp=1", bus.req1_ready); end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.alu_ctrl !== 4'b0000 || bus.busy !== 1'b1) begin failures++;
      $display("FAIL ill_exec_ctrl got=%h busy=%0b exp=0,1", bus.alu_ctrl, bus.busy); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp_result !== 64'h0 || bus.rsp_err !== 1'b1)
    begin failures++;
      $display("FAIL ill_rsp valid=%0b got=%h err=%0b exp=1,0,1", bus.rsp1_valid,
               bus.rsp_result, bus.rsp_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_exec();
    // Serve req0 first so the pointer differs from its reset value.
    bus.req0_a = 64'd7; bus.req0_b = 64'd1; bus.req0_op = 4'b0110;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    bus.req0_a = 64'd9; bus.req0_b = 64'd9; bus.req0_op = 4'b0000;
    bus.req0_valid = 1'b1;
    @(posedge clk); #1;
    bus.req1_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.alu_ctrl !== 4'b0000 || bus.alu_a !== 64'h0) begin
      failures++;
      $display("FAIL mid_reset_async busy=%0b ctrl=%h alu_a=%h exp=0,0,0", bus.busy,
               bus.alu_ctrl, bus.alu_a); end
    checks++; if ({bus.req1_ready, bus.req0_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'b0000)
    begin failures++;
      $display("FAIL mid_reset_hs got=%b exp=0000",
               {bus.req1_ready, bus.req0_ready, bus.rsp0_valid, bus.rsp1_valid}); end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.rsp0_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++;
        $display("FAIL mid_reset_no_rsp cyc=%0d rsp0_valid=%0b busy=%0b exp=0,0", i,
                 bus.rsp0_valid, bus.busy); end
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    @(negedge clk);
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin failures++;
      $display("FAIL mid_reset_tie got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp_result !== 64'd9) begin failures++;
      $display("FAIL mid_reset_reissue valid=%0b got=%h exp=1,9", bus.rsp0_valid,
               bus.rsp_result); end
    @(posedge clk); #1;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_tie();
    test_round_robin();
    test_single();
    test_backpressure();
    test_illegal();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
